// File: rtl/tt_pkg.sv
// tt_pkg: shared types and constants for the truth-table sweep controller.
//   state_e          - sweep FSM state encoding (IDLE, RUN, DONE)
//   N_IN / N_COMB    - number of function inputs and input combinations
//   HOLD_MIN/MAX     - legal range of the per-combination hold time
package tt_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;
    localparam int N_IN     = 4;
    localparam int N_COMB   = 16;
    localparam int HOLD_MIN = 1;
    localparam int HOLD_MAX = 255;
endpackage

// File: rtl/tt_hold_timer.sv
// tt_hold_timer: per-combination hold counter with clear and terminal count.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_clr          - force the count to zero
//   i_en           - advance the count
//   o_tc           - count has reached HOLD-1 (last cycle of the hold window)
module tt_hold_timer #(
    parameter int HOLD = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [W-1:0] LAST = W'(HOLD - 1);

    logic [W-1:0] hcnt_q, hcnt_d;

    assign o_tc = hcnt_q == LAST;

    // Terminal count wraps to zero so the next combination starts a fresh window.
    always_comb hcnt_d = (i_clr || o_tc) ? '0 : i_en ? hcnt_q + 1'b1 : hcnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) hcnt_q <= '0;
        else          hcnt_q <= hcnt_d;
    end
endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: drives all 16 input combinations onto a 4-input function and
// captures its output into a truth table.
//   i_clk, i_rst_n   - clock, asynchronous active-low reset
//   i_start          - start request, sampled only in IDLE
//   i_y              - output of the function under test
//   o_a..o_d         - function inputs, {a,b,c,d} = combination index
//   o_busy           - sweep running
//   o_done           - one-cycle pulse after the last sample
//   o_tt             - captured truth table, bit k = y for combination k
module tt_sweep_ctrl
    import tt_pkg::*;
#(
    parameter int HOLD_CYCLES = 10
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_y,
    output logic                o_a,
    output logic                o_b,
    output logic                o_c,
    output logic                o_d,
    output logic                o_busy,
    output logic                o_done,
    output logic [N_COMB-1:0]   o_tt
);
    state_e              state_q, state_d;
    logic [N_IN-1:0]     idx_q, idx_d;
    logic [N_COMB-1:0]   tt_q, tt_d;
    logic                tc;

    tt_hold_timer #(.HOLD(HOLD_CYCLES)) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (state_q != ST_RUN),
        .i_en    (state_q == ST_RUN),
        .o_tc    (tc)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tt_d    = tt_q;
        case (state_q)
            ST_IDLE: if (i_start) begin
                state_d = ST_RUN;
                idx_d   = '0;
                tt_d    = '0;
            end
            ST_RUN: if (tc) begin
                tt_d[idx_q] = i_y;
                // Index wraps to 0 on the last combination, parking the outputs at 0000.
                idx_d       = idx_q + 1'b1;
                state_d     = (idx_q == N_IN'(N_COMB - 1)) ? ST_DONE : ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tt_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_q    <= tt_d;
        end
    end

    assign {o_a, o_b, o_c, o_d} = idx_q;
    assign o_busy = state_q == ST_RUN;
    assign o_done = state_q == ST_DONE;
    assign o_tt   = tt_q;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: scoreboard bench for tt_sweep_ctrl at HOLD_CYCLES=10 and 1.
module tb_tt_sweep_ctrl;
    typedef struct {
        logic [15:0] tt;
        int          len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start10 = 1'b0, start1 = 1'b0;
    logic        mode1 = 1'b0;
    logic        a10, b10, c10, d10, busy10, done10, y10;
    logic        a1, b1, c1, d1, busy1, done1, y1;
    logic [15:0] tt10, tt1;
    int          tests = 0, fails = 0;
    int          blen10 = 0, blen1 = 0;
    exp_t        q10[$], q1[$];

    always #5 clk = ~clk;

    assign y10 = a10 & b10;
    assign y1  = mode1 ? 1'b1 : (a1 ^ b1 ^ c1 ^ d1);

    tt_sweep_ctrl #(.HOLD_CYCLES(10)) u10 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start10), .i_y(y10),
        .o_a(a10), .o_b(b10), .o_c(c10), .o_d(d10),
        .o_busy(busy10), .o_done(done10), .o_tt(tt10)
    );

    tt_sweep_ctrl #(.HOLD_CYCLES(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_y(y1),
        .o_a(a1), .o_b(b1), .o_c(c1), .o_d(d1),
        .o_busy(busy1), .o_done(done1), .o_tt(tt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input bit sel, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 400) begin
            @(negedge clk);
            n++;
            ok = sel ? done1 : done10;
        end
    endtask

    // Monitors: pop the expected result on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) blen10 = 0;
        else begin
            if (busy10) blen10++;
            if (done10) begin
                if (q10.size() == 0) chk("u10_unexpected_done", 1, 0);
                else begin
                    e = q10.pop_front();
                    chk("u10_tt", tt10, e.tt);
                    chk("u10_busy_len", blen10, e.len);
                    chk("u10_abcd_at_done", {a10, b10, c10, d10}, 0);
                    chk("u10_busy_at_done", busy10, 0);
                end
                blen10 = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) blen1 = 0;
        else begin
            if (busy1) blen1++;
            if (done1) begin
                if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("u1_tt", tt1, e.tt);
                    chk("u1_busy_len", blen1, e.len);
                    chk("u1_abcd_at_done", {a1, b1, c1, d1}, 0);
                    chk("u1_busy_at_done", busy1, 0);
                end
                blen1 = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        int n;
        logic bad;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out10", {a10, b10, c10, d10, busy10, done10, tt10}, 0);
        chk("rst_out1", {a1, b1, c1, d1, busy1, done1, tt1}, 0);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bad |= |{a10, b10, c10, d10, busy10, done10, tt10, a1, b1, c1, d1, busy1, done1, tt1};
        end
        chk("idle_quiet", bad, 0);

        // y=a&b, HOLD=10
        q10.push_back('{16'hF000, 160});
        start10 = 1'b1;
        @(negedge clk) start10 = 1'b0;
        chk("t2_busy_after_start", busy10, 1);
        wait_done(1'b0, ok, n);
        chk("t2_done_seen", ok, 1);
        @(negedge clk);
        chk("t2_abcd_after", {a10, b10, c10, d10}, 0);
        chk("t2_tt_hold", tt10, 16'hF000);

        // y=a^b^c^d, HOLD=1, one step per cycle
        q1.push_back('{16'h6996, 16});
        start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        chk("t3_step0", {a1, b1, c1, d1}, 0);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            chk("t3_step", {a1, b1, c1, d1}, i);
        end
        wait_done(1'b1, ok, n);
        chk("t3_done_seen", ok, 1);
        chk("t3_done_latency", n, 1);

        // Start pulses during RUN and DONE are ignored
        q10.push_back('{16'hF000, 160});
        start10 = 1'b1;
        @(negedge clk) start10 = 1'b0;
        repeat (40) @(negedge clk);
        start10 = 1'b1;
        @(negedge clk) start10 = 1'b0;
        repeat (60) @(negedge clk);
        start10 = 1'b1;
        repeat (3) @(negedge clk);
        start10 = 1'b0;
        wait_done(1'b0, ok, n);
        chk("t4_done_seen", ok, 1);
        start10 = 1'b1;
        @(negedge clk) start10 = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_no_restart", busy10, 0);
        chk("t4_tt_unchanged", tt10, 16'hF000);

        // Start held high, y=1: back-to-back sweeps, 18-cycle period
        mode1 = 1'b1;
        repeat (3) q1.push_back('{16'hFFFF, 16});
        start1 = 1'b1;
        @(negedge clk);
        chk("t6_tt_cleared_first", tt1, 0);
        chk("t6_busy_first", busy1, 1);
        for (int s = 0; s < 3; s++) begin
            wait_done(1'b1, ok, n);
            chk("t6_done_seen", ok, 1);
            chk("t6_period", (s == 0) ? n : n + 2, (s == 0) ? 16 : 18);
            if (s == 2) start1 = 1'b0;
            else begin
                @(negedge clk);
                chk("t6_idle_tt_hold", {busy1, tt1}, {1'b0, 16'hFFFF});
                @(negedge clk);
                chk("t6_tt_cleared_restart", {busy1, tt1}, {1'b1, 16'h0000});
            end
        end
        repeat (4) @(negedge clk);
        chk("t6_stopped", busy1, 0);

        // Async reset mid-sweep at idx=7
        start10 = 1'b1;
        @(negedge clk) start10 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = {a10, b10, c10, d10} == 4'd7;
        end
        chk("t5_reached_idx7", ok, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_out10", {a10, b10, c10, d10, busy10, done10, tt10}, 0);
        chk("t5_async_tt1", tt1, 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_not_resumed", {busy10, a10, b10, c10, d10}, 0);
        q10.push_back('{16'hF000, 160});
        start10 = 1'b1;
        @(negedge clk) start10 = 1'b0;
        wait_done(1'b0, ok, n);
        chk("t5_fresh_done_seen", ok, 1);

        repeat (5) @(negedge clk);
        chk("q10_drained", q10.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
